// File: rtl/apb_adc_seq.sv
// apb_adc_seq: APB-controlled ADC channel sequencer with sample FIFO.
// Scans the enabled mux channels, waits for the mux to settle, and captures
// each converter result as {channel, sample} into a FIFO that is popped by
// reading the DATA register.
// Optional build macro APB_ADC_SEQ_IRQ_EN adds the THRESH register at 0x10
// and the FIFO level interrupt; without it irq is tied low.
module apb_adc_seq #(
    parameter int N_CH       = 4,
    parameter int ADC_W      = 12,
    parameter int FIFO_DEPTH = 8,
    parameter int SETTLE_CYC = 2,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             PCLK,
    input  logic             PRESETn,
    input  logic             PSEL,
    input  logic             PENABLE,
    input  logic             PWRITE,
    input  logic [11:0]      PADDR,
    input  logic [31:0]      PWDATA,
    output logic [31:0]      PRDATA,
    output logic             PREADY,
    output logic             PSLVERR,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_VALID,
    output logic [CH_W-1:0]  ADC_CH,
    output logic             sample_enable,
    output logic             adc2tmu_en,
    output logic             irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = CH_W + ADC_W;

    typedef enum logic [1:0] {IDLE, SETTLE, WAIT} state_t;

    state_t            state, state_next;
    logic [CH_W-1:0]   ch, ch_next;
    logic [7:0]        cnt, cnt_next;
    logic              push, run;

    logic              en_reg, tmu_reg, ovf;
    logic [N_CH-1:0]   chmask;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level, level_next;
    logic [EW-1:0]     mem [FIFO_DEPTH];
    logic [EW-1:0]     head;

    logic access, wr, rd, mapped;
    logic sel_ctrl, sel_mask, sel_status, sel_data, sel_thresh;
    logic full, empty, pop, clear, push_ok;
    logic unused_pwdata;

    // Lowest enabled channel in the mask (0 when the mask is empty).
    function automatic logic [CH_W-1:0] lowest_ch(input logic [N_CH-1:0] m);
        logic [CH_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) r = CH_W'(i);
        end
        return r;
    endfunction

    // Next enabled channel strictly above cur, wrapping to the lowest one.
    function automatic logic [CH_W-1:0] next_ch(input logic [N_CH-1:0] m,
                                                input logic [CH_W-1:0] cur);
        logic [CH_W-1:0] r;
        r = lowest_ch(m);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(cur))) r = CH_W'(i);
        end
        return r;
    endfunction

    assign access     = PSEL & PENABLE;
    assign wr         = access & PWRITE;
    assign rd         = access & ~PWRITE;
    assign sel_ctrl   = (PADDR == 12'h000);
    assign sel_mask   = (PADDR == 12'h004);
    assign sel_status = (PADDR == 12'h008);
    assign sel_data   = (PADDR == 12'h00C);
`ifdef APB_ADC_SEQ_IRQ_EN
    assign sel_thresh = (PADDR == 12'h010);
`else
    assign sel_thresh = 1'b0;
`endif
    assign mapped  = sel_ctrl | sel_mask | sel_status | sel_data | sel_thresh;
    assign PSLVERR = access & ~mapped;
    assign PREADY  = 1'b1;

    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign pop     = rd & sel_data & ~empty;
    assign clear   = wr & sel_ctrl & PWDATA[2];
    assign push_ok = push & (~full | pop);
    assign head    = mem[rd_ptr];
    assign run     = en_reg & (|chmask);

    assign ADC_CH        = ch;
    assign sample_enable = en_reg;
    assign adc2tmu_en    = tmu_reg;
    assign unused_pwdata = ^PWDATA;

    // Control registers written in the APB access phase.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            en_reg  <= 1'b0;
            tmu_reg <= 1'b0;
            chmask  <= '0;
        end else begin
            if (wr & sel_ctrl) begin
                en_reg  <= PWDATA[0];
                tmu_reg <= PWDATA[1];
            end
            if (wr & sel_mask) chmask <= PWDATA[N_CH-1:0];
        end
    end

    // Sequencer state, current channel and settle counter.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
            ch    <= '0;
            cnt   <= '0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: the mask is only consulted when entering a scan or
    // advancing channel; losing enable or mask aborts from any state.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        cnt_next   = cnt;
        push       = 1'b0;
        if (!run) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = SETTLE;
                    ch_next    = lowest_ch(chmask);
                    cnt_next   = '0;
                end
                SETTLE: begin
                    if (cnt == 8'(SETTLE_CYC - 1)) state_next = WAIT;
                    else                           cnt_next   = cnt + 8'd1;
                end
                WAIT: begin
                    if (ADC_VALID) begin
                        push       = 1'b1;
                        ch_next    = next_ch(chmask, ch);
                        state_next = SETTLE;
                        cnt_next   = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // FIFO occupancy after this cycle; clear wins over push and pop.
    always_comb begin
        level_next = level;
        if (clear) begin
            level_next = '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   level_next = level + (AW+1)'(1);
                2'b01:   level_next = level - (AW+1)'(1);
                default: level_next = level;
            endcase
        end
    end

    // FIFO pointers and level.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            level <= level_next;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop)     rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Sticky overflow: a dropped push sets it, W1C on STATUS[10] clears it.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            ovf <= 1'b0;
        end else begin
            if (wr & sel_status & PWDATA[10]) ovf <= 1'b0;
            if (push & full & ~pop & ~clear)  ovf <= 1'b1;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge PCLK) begin
        if (push_ok & ~clear) mem[wr_ptr] <= {ch, ADC_DATA};
    end

`ifdef APB_ADC_SEQ_IRQ_EN
    logic [7:0] thresh;

    // Threshold register and level interrupt, registered from the new level.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            thresh <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr & sel_thresh) thresh <= PWDATA[7:0];
            irq <= (8'(level_next) >= thresh) & (thresh != 8'd0);
        end
    end
`else
    assign irq = 1'b0;
`endif

    // Read mux; zero when not selected or when the offset is unmapped.
    always_comb begin
        PRDATA = '0;
        if (PSEL) begin
            if (sel_ctrl) begin
                PRDATA[0] = en_reg;
                PRDATA[1] = tmu_reg;
            end else if (sel_mask) begin
                PRDATA[N_CH-1:0] = chmask;
            end else if (sel_status) begin
                PRDATA[7:0] = 8'(level);
                PRDATA[8]   = empty;
                PRDATA[9]   = full;
                PRDATA[10]  = ovf;
            end else if (sel_data) begin
                if (!empty) begin
                    PRDATA[31]           = 1'b1;
                    PRDATA[16 +: CH_W]   = head[ADC_W +: CH_W];
                    PRDATA[ADC_W-1:0]    = head[ADC_W-1:0];
                end
`ifdef APB_ADC_SEQ_IRQ_EN
            end else if (sel_thresh) begin
                PRDATA[7:0] = thresh;
`endif
            end
        end
    end
endmodule

// File: tb/tb_apb_adc_seq.sv
// Self-checking bench for apb_adc_seq (4 channels, 12-bit, 8-deep FIFO,
// 3 settle cycles). Captured samples are queued as expected DATA words and
// compared as DATA reads pop them.
module tb_apb_adc_seq;
    localparam int N_CH = 4, ADC_W = 12, FIFO_DEPTH = 8, SETTLE_CYC = 3, CH_W = 2;

    logic             PCLK, PRESETn, PSEL, PENABLE, PWRITE;
    logic [11:0]      PADDR;
    logic [31:0]      PWDATA, PRDATA;
    logic             PREADY, PSLVERR;
    logic [ADC_W-1:0] ADC_DATA;
    logic             ADC_VALID;
    logic [CH_W-1:0]  ADC_CH;
    logic             sample_enable, adc2tmu_en, irq;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] sb[$];

    apb_adc_seq #(.N_CH(N_CH), .ADC_W(ADC_W), .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYC(SETTLE_CYC)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .ADC_DATA(ADC_DATA), .ADC_VALID(ADC_VALID), .ADC_CH(ADC_CH),
        .sample_enable(sample_enable), .adc2tmu_en(adc2tmu_en), .irq(irq)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
        tick();
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [11:0] a, output logic [31:0] d, output logic err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        tick();
        PENABLE = 1'b1;
        #1 d = PRDATA; err = PSLVERR;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // One converter strobe while the sequencer waits; returns in WAIT again.
    task automatic pulse(input logic [CH_W-1:0] ch, input logic [ADC_W-1:0] d);
        ADC_DATA = d; ADC_VALID = 1'b1;
        if (sb.size() < FIFO_DEPTH) sb.push_back(32'h8000_0000 | (32'(ch) << 16) | 32'(d));
        tick();
        ADC_VALID = 1'b0;
        repeat (SETTLE_CYC) tick();
    endtask

    task automatic test_reset;
        logic [31:0] rd; logic err;
        PRESETn = 1'b0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 12'h008; PWDATA = 0;
        ADC_DATA = 0; ADC_VALID = 0;
        repeat (3) tick();
        PRESETn = 1'b1;
        tick();
        n_checks++; if ({sample_enable, adc2tmu_en, irq} !== 3'b000) begin n_errors++;
            $display("FAIL reset_outs: got %b required 000", {sample_enable, adc2tmu_en, irq}); end
        n_checks++; if (ADC_CH !== 2'd0) begin n_errors++;
            $display("FAIL reset_ch: got %0d required 0", ADC_CH); end
        n_checks++; if (PREADY !== 1'b1) begin n_errors++;
            $display("FAIL pready: got %b required 1", PREADY); end
        n_checks++; if (PRDATA !== 32'h0) begin n_errors++;
            $display("FAIL prdata_nosel: got %h required 0", PRDATA); end
        apb_read(12'h000, rd, err);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_ctrl: got %h required 0", rd); end
        apb_read(12'h004, rd, err);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_mask: got %h required 0", rd); end
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h100) begin n_errors++; $display("FAIL reset_status: got %h required 100", rd); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL status_err: got %b required 0", err); end
    endtask

    task automatic test_scan;
        logic [31:0] rd, exp; logic err;
        logic [CH_W-1:0] ch_seq [3];
        logic [ADC_W-1:0] d_seq [3];
        ch_seq = '{2'd1, 2'd3, 2'd1};
        d_seq  = '{12'h123, 12'h456, 12'h789};
        apb_write(12'h004, 32'hA, err);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 12'h000; PWDATA = 32'h1;
        tick();
        n_checks++; if (sample_enable !== 1'b0) begin n_errors++;
            $display("FAIL setup_side_effect: sample_enable got %b required 0", sample_enable); end
        PENABLE = 1'b1;
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        n_checks++; if (sample_enable !== 1'b1) begin n_errors++;
            $display("FAIL en_latency: sample_enable got %b required 1", sample_enable); end
        repeat (1 + SETTLE_CYC) tick();
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (ADC_CH !== ch_seq[i]) begin n_errors++;
                $display("FAIL scan_ch%0d: got %0d required %0d", i, ADC_CH, ch_seq[i]); end
            pulse(ch_seq[i], d_seq[i]);
        end
        for (int i = 0; i < 3; i++) begin
            apb_read(12'h00C, rd, err);
            exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
            n_checks++; if (rd !== exp) begin n_errors++;
                $display("FAIL scan_data%0d: got %h required %h", i, rd, exp); end
        end
        apb_write(12'h000, 32'h0, err);
        tick();
    endtask

    task automatic test_overflow;
        logic [31:0] rd, exp; logic err;
        apb_write(12'h004, 32'h1, err);
        apb_write(12'h000, 32'h1, err);
        repeat (1 + SETTLE_CYC) tick();
        for (int i = 0; i < 9; i++) pulse(2'd0, ADC_W'(12'h200 + i));
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h608) begin n_errors++; $display("FAIL ovf_status: got %h required 608", rd); end
        apb_write(12'h008, 32'h400, err);
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h208) begin n_errors++; $display("FAIL ovf_w1c: got %h required 208", rd); end
        for (int i = 0; i < 9; i++) begin
            apb_read(12'h00C, rd, err);
            exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
            n_checks++; if (rd !== exp) begin n_errors++;
                $display("FAIL ovf_pop%0d: got %h required %h", i, rd, exp); end
        end
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h100) begin n_errors++; $display("FAIL empty_pop: got %h required 100", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd, exp; logic err;
        for (int i = 0; i < FIFO_DEPTH; i++) pulse(2'd0, ADC_W'($urandom_range(0, 4095)));
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h00C;
        tick();
        PENABLE = 1'b1; ADC_VALID = 1'b1; ADC_DATA = 12'hABC;
        #1 rd = PRDATA;
        exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        sb.push_back(32'h8000_0ABC);
        n_checks++; if (rd !== exp) begin n_errors++; $display("FAIL full_pop: got %h required %h", rd, exp); end
        tick();
        PSEL = 1'b0; PENABLE = 1'b0; ADC_VALID = 1'b0;
        repeat (SETTLE_CYC) tick();
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h208) begin n_errors++; $display("FAIL full_pushpop: got %h required 208", rd); end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            apb_read(12'h00C, rd, err);
            exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
            n_checks++; if (rd !== exp) begin n_errors++;
                $display("FAIL drain%0d: got %h required %h", i, rd, exp); end
        end
        apb_write(12'h000, 32'h0, err);
        tick();
    endtask

    task automatic test_settle;
        logic [31:0] rd, exp; logic err;
        apb_write(12'h004, 32'h4, err);
        apb_write(12'h000, 32'h1, err);
        ADC_VALID = 1'b1; ADC_DATA = 12'hAAA;
        repeat (1 + SETTLE_CYC) tick();
        ADC_DATA = 12'h5B5;
        sb.push_back(32'h8002_05B5);
        tick();
        ADC_VALID = 1'b0;
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h001) begin n_errors++; $display("FAIL settle_level: got %h required 001", rd); end
        apb_read(12'h00C, rd, err);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        n_checks++; if (rd !== exp) begin n_errors++; $display("FAIL settle_data: got %h required %h", rd, exp); end
        repeat (SETTLE_CYC) tick();
        pulse(2'd2, 12'h111);
        pulse(2'd2, 12'h222);
        apb_write(12'h000, 32'h5, err);
        sb.delete();
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h100) begin n_errors++; $display("FAIL clear_status: got %h required 100", rd); end
        apb_read(12'h000, rd, err);
        n_checks++; if (rd !== 32'h1) begin n_errors++; $display("FAIL clear_ctrl: got %h required 1", rd); end
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic err;
        apb_write(12'h000, 32'h0, err);
        ADC_VALID = 1'b1; ADC_DATA = 12'h333;
        repeat (3) tick();
        ADC_VALID = 1'b0;
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h100) begin n_errors++; $display("FAIL abort_nopush: got %h required 100", rd); end
        n_checks++; if (ADC_CH !== 2'd2) begin n_errors++; $display("FAIL abort_chhold: got %0d required 2", ADC_CH); end
        apb_write(12'h000, 32'h3, err);
        ADC_VALID = 1'b1;
        repeat (1 + SETTLE_CYC) tick();
        ADC_VALID = 1'b0;
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h100) begin n_errors++; $display("FAIL restart_idle: got %h required 100", rd); end
        pulse(2'd2, 12'h444);
        pulse(2'd2, 12'h555);
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h002) begin n_errors++; $display("FAIL prereset_level: got %h required 002", rd); end
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        sb.delete();
        n_checks++; if ({sample_enable, adc2tmu_en, irq, ADC_CH} !== 5'b0) begin n_errors++;
            $display("FAIL midreset_outs: got %b required 00000", {sample_enable, adc2tmu_en, irq, ADC_CH}); end
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h100) begin n_errors++; $display("FAIL midreset_status: got %h required 100", rd); end
        apb_read(12'h004, rd, err);
        n_checks++; if (rd !== 32'h0) begin n_errors++; $display("FAIL midreset_mask: got %h required 0", rd); end
    endtask

    task automatic test_unmapped;
        logic [31:0] rd; logic err;
        apb_write(12'h014, 32'hFFFF_FFFF, err);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL unmapped_werr: got %b required 1", err); end
        apb_read(12'h014, rd, err);
        n_checks++; if ({err, rd} !== {1'b1, 32'h0}) begin n_errors++;
            $display("FAIL unmapped_read: got err=%b data=%h required err=1 data=0", err, rd); end
    endtask

    task automatic test_irq;
        logic [31:0] rd, exp; logic err;
`ifdef APB_ADC_SEQ_IRQ_EN
        apb_write(12'h010, 32'h4, err);
        apb_read(12'h010, rd, err);
        n_checks++; if (rd !== 32'h4) begin n_errors++; $display("FAIL thresh_rb: got %h required 4", rd); end
        apb_write(12'h004, 32'h1, err);
        apb_write(12'h000, 32'h1, err);
        repeat (1 + SETTLE_CYC) tick();
        for (int i = 0; i < 3; i++) pulse(2'd0, ADC_W'(12'h030 + i));
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_below: got %b required 0", irq); end
        ADC_DATA = 12'h033; ADC_VALID = 1'b1;
        sb.push_back(32'h8000_0033);
        tick();
        ADC_VALID = 1'b0;
        n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_rise: got %b required 1", irq); end
        repeat (SETTLE_CYC) tick();
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h00C;
        tick();
        PSEL = 1'b0;
        tick();
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h004) begin n_errors++; $display("FAIL setup_nopop: got %h required 004", rd); end
        apb_read(12'h00C, rd, err);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        n_checks++; if (rd !== exp) begin n_errors++; $display("FAIL irq_pop: got %h required %h", rd, exp); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_fall: got %b required 0", irq); end
`else
        apb_read(12'h010, rd, err);
        n_checks++; if ({err, rd} !== {1'b1, 32'h0}) begin n_errors++;
            $display("FAIL thresh_unmapped: got err=%b data=%h required err=1 data=0", err, rd); end
        apb_write(12'h004, 32'h1, err);
        apb_write(12'h000, 32'h1, err);
        repeat (1 + SETTLE_CYC) tick();
        for (int i = 0; i < 5; i++) pulse(2'd0, ADC_W'(12'h030 + i));
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h005) begin n_errors++; $display("FAIL noirq_level: got %h required 005", rd); end
        n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_tied: got %b required 0", irq); end
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 12'h00C;
        tick();
        PSEL = 1'b0;
        tick();
        apb_read(12'h008, rd, err);
        n_checks++; if (rd !== 32'h005) begin n_errors++; $display("FAIL setup_nopop: got %h required 005", rd); end
        apb_read(12'h00C, rd, err);
        exp = (sb.size() != 0) ? sb.pop_front() : 32'h0;
        n_checks++; if (rd !== exp) begin n_errors++; $display("FAIL noirq_pop: got %h required %h", rd, exp); end
`endif
    endtask

    initial begin
        test_reset();
        test_scan();
        test_overflow();
        test_back_to_back();
        test_settle();
        test_abort();
        test_unmapped();
        test_irq();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_adc_seq.md
APB_ADC_SEQ -- requirements
Module: apb_adc_seq

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of ADC mux channels (2..16).
REQ-002 SHALL have parameter ADC_W, default 12, ADC sample width (8..16).
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, sample FIFO entries (power of 2, 2..64).
REQ-004 SHALL have parameter SETTLE_CYC, default 2, mux settle cycles after a channel change (1..255).
REQ-005 SHALL have the following ports; CH_W = clog2(N_CH); one clock; reset is synchronous and active-low.
- PCLK  in  1  sole clock, rising edge.
- PRESETn  in  1  synchronous active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  12  byte address.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data.
- PREADY  out  1  ready.
- PSLVERR  out  1  error.
- ADC_DATA  in  ADC_W  converter result.
- ADC_VALID  in  1  one-cycle result strobe.
- ADC_CH  out  CH_W  mux select.
- sample_enable  out  1  converter run.
- adc2tmu_en  out  1  downstream enable.
- irq  out  1  FIFO level interrupt.

Function
REQ-006 SHALL tie PREADY to 1 (zero wait states).
REQ-007 SHALL perform register writes and FIFO pops only in the APB access phase (PSEL & PENABLE); the setup phase has no side effects.
REQ-008 SHALL drive PRDATA combinationally from the addressed register, and drive 0 when PSEL=0.
REQ-009 SHALL assert PSLVERR in the access phase to an unmapped offset; such writes are ignored and reads return 0.
REQ-010 SHALL implement the following register map.
- 0x00 CTRL RW: [0] sample_enable, [1] adc2tmu_en, [2] FIFO clear (write-1, self-clearing, reads 0).
- 0x04 CHMASK RW: [N_CH-1:0] channel enables.
- 0x08 STATUS: [7:0] level RO, [8] empty RO, [9] full RO, [10] overflow W1C.
- 0x0C DATA RO, pop on read: [31] valid, [19:16] channel, [ADC_W-1:0] sample; all other bits 0.
REQ-011 SHALL sequence channels with FSM states IDLE, SETTLE and WAIT.
REQ-012 SHALL transition IDLE->SETTLE when sample_enable=1 and CHMASK!=0, setting ADC_CH to the lowest enabled channel.
REQ-013 SHALL remain in SETTLE for exactly SETTLE_CYC cycles, then enter WAIT.
REQ-014 SHALL, in WAIT on ADC_VALID=1, push {ADC_CH, ADC_DATA} in the same cycle, then set ADC_CH to the next enabled channel above the current one (wrapping to the lowest) and enter SETTLE.
REQ-015 SHALL ignore ADC_VALID outside WAIT.
REQ-016 SHALL return to IDLE on the next cycle whenever sample_enable=0 or CHMASK=0, discarding any in-flight capture; ADC_CH holds its value.
REQ-017 SHALL not use a CHMASK change in SETTLE or WAIT until the next channel advance.
REQ-018 SHALL, on a push while full without a simultaneous pop, drop the sample and set overflow, which stays set until W1C.
REQ-019 SHALL, on simultaneous push and pop, perform both: level unchanged, no overflow, even when full.
REQ-020 SHALL, on a DATA read while empty, return 0 with valid=0 and leave pointers unchanged.
REQ-021 SHALL, on FIFO clear, reset pointers and level in that cycle, with clear taking priority over a same-cycle push or pop; overflow is unaffected.
REQ-022 SHALL give sample_enable and adc2tmu_en a 1-cycle latency from the access phase.

Reset
REQ-023 SHALL, when PRESETn=0 at a PCLK edge, clear CTRL, CHMASK, overflow, FIFO pointers and level, set FSM=IDLE and ADC_CH=0, and drive sample_enable, adc2tmu_en and irq to 0.
REQ-024 SHALL make reset mid-scan discard FIFO contents; FIFO storage RAM need not be reset.

Configuration
REQ-025 SHALL, with APB_ADC_SEQ_IRQ_EN defined, implement 0x10 THRESH RW [7:0] (reset 0), with irq registered as (level >= THRESH) & (THRESH != 0).
REQ-026 SHALL, without APB_ADC_SEQ_IRQ_EN, tie irq to 0 and treat 0x10 as unmapped (PSLVERR=1).

Verification
REQ-027 SHALL cover: CHMASK=0b1010, sample_enable=1, ADC_VALID with 0x123, 0x456 and 0x789 -> ADC_CH sequence 1,3,1; DATA reads return 0x80010123, 0x80030456, 0x80010789.
REQ-028 SHALL cover: 9 captures with no reads, FIFO_DEPTH=8 -> STATUS full=1, overflow=1, level=8; W1C bit10 -> overflow=0; 8 reads pop in order; 9th read returns 0.
REQ-029 SHALL cover: FIFO full, ADC_VALID coincident with DATA access phase -> level stays 8, overflow stays 0.
REQ-030 SHALL cover: SETTLE_CYC=3 -> ADC_VALID in SETTLE cycles 1-3 is ignored; the first ADC_VALID in WAIT is captured.
REQ-031 SHALL cover: sample_enable cleared while in WAIT, followed by ADC_VALID -> no push, FSM=IDLE; PRESETn low for one cycle mid-scan -> all outputs and STATUS at reset values.
REQ-032 SHALL cover: with APB_ADC_SEQ_IRQ_EN, THRESH=4 -> irq rises on the cycle after the 4th push and falls after the pop to level 3; setup phase only at 0x0C -> no pop.
